// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//
// The tracking FIFO stores one entry per outstanding memory transaction.
// Each entry holds the source that issued the request and the 32-bit lane
// index within the memory word. Instruction responses use that lane index
// to pick their 32 bits out of a wider memory word.
//
// The lane field is sized for the widest memory word supported (512 bits).
// For narrower words the unused upper lane bits are always zero.

package mem_arb_pkg;

   // Requester identity. The encoding matches the src field of a tracking entry.
   typedef enum logic [1:0] {
      SRC_INSTR = 2'd0,
      SRC_DATA  = 2'd1,
      SRC_XIF   = 2'd2
   } src_e;

   localparam int MEM_W_MAX = 512;

   // Number of address bits that select a 32-bit lane inside a MEM_W word.
   function automatic int calc_lane_w(input int mem_w);
      return $clog2(mem_w / 8) - 2;
   endfunction

   // Storage width of the lane field. This covers every legal MEM_W.
   localparam int LANE_W = $clog2(MEM_W_MAX / 8) - 2;

   typedef struct packed {
      src_e              src;
      logic [LANE_W-1:0] lane;
   } trk_entry_t;

   localparam int ENTRY_W = $bits(trk_entry_t);

endpackage

// File: rtl/mem_arb_trk_fifo.sv
// In-order tracking FIFO for outstanding memory transactions.
//
// Parameters:
//   DEPTH  - number of entries (power of two, at least 2)
//   WIDTH  - entry width in bits
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset; discards all entries
//   push_i       - write push_data_i at the tail
//   push_data_i  - entry to store
//   pop_i        - drop the head entry (ignored while empty)
//   head_o       - current head entry (valid when !empty_o)
//   count_o      - current occupancy, 0..DEPTH
//   full_o       - count_o == DEPTH
//   empty_o      - count_o == 0
//
// A push while full is accepted only if a pop happens in the same cycle.
// The pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
// without any extra logic.

module mem_arb_trk_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] entries_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = entries_q[rd_ptr_q];

   // A pop on an empty FIFO is dropped. A push into a full FIFO is allowed
   // only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Entry storage has no reset. Only the pointers and the count decide
   // which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         entries_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
   // cancel out in the count.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SoC memory port between three requesters:
//   - cv32e40x instruction fetch (instr)
//   - cv32e40x data interface (data)
//   - XAVA coprocessor (xif)
//
// Every granted request is recorded in an in-order tracking FIFO. Each
// memory response is routed back only to the requester that issued it.
// Instruction fetch is promoted to top priority after STARVE_LIM
// consecutive denied cycles.
//
// Optional feature:
//   MEM_ARB_RR_EN - when defined, data and xif alternate priority whenever
//                   they contend. When undefined, data always beats xif.
//
// Parameters: MEM_W (memory data width), DEPTH (maximum outstanding
// transactions), STARVE_LIM (denied cycles before instr is promoted).
// Ports:
//   clk_i, rst_i                         - clock, synchronous active-high reset
//   instr_req_i/addr_i, instr_gnt_o      - fetch request / accept
//   instr_rvalid_o/rdata_o/err_o         - fetch response (32-bit lane)
//   data_req_i/addr/we/be/wdata, gnt_o   - core load/store request / accept
//   data_rvalid_o/rdata_o/err_o          - core load/store response
//   xif_req_i/addr/we/be/wdata, gnt_o    - coprocessor request / accept
//   xif_rvalid_o/rdata_o/err_o           - coprocessor response
//   mem_req_o/addr/we/be/wdata           - memory request (always accepted)
//   mem_rvalid_i/err_i/rdata_i           - in-order memory response
//   outstanding_o                        - tracking FIFO occupancy
//   unexp_rsp_o                          - sticky: response with nothing outstanding

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_W      = 32,
   parameter int DEPTH      = 8,
   parameter int STARVE_LIM = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,

   input  logic                   instr_req_i,
   input  logic [31:0]            instr_addr_i,
   output logic                   instr_gnt_o,
   output logic                   instr_rvalid_o,
   output logic [31:0]            instr_rdata_o,
   output logic                   instr_err_o,

   input  logic                   data_req_i,
   input  logic [31:0]            data_addr_i,
   input  logic                   data_we_i,
   input  logic [MEM_W/8-1:0]     data_be_i,
   input  logic [MEM_W-1:0]       data_wdata_i,
   output logic                   data_gnt_o,
   output logic                   data_rvalid_o,
   output logic [MEM_W-1:0]       data_rdata_o,
   output logic                   data_err_o,

   input  logic                   xif_req_i,
   input  logic [31:0]            xif_addr_i,
   input  logic                   xif_we_i,
   input  logic [MEM_W/8-1:0]     xif_be_i,
   input  logic [MEM_W-1:0]       xif_wdata_i,
   output logic                   xif_gnt_o,
   output logic                   xif_rvalid_o,
   output logic [MEM_W-1:0]       xif_rdata_o,
   output logic                   xif_err_o,

   output logic                   mem_req_o,
   output logic [31:0]            mem_addr_o,
   output logic                   mem_we_o,
   output logic [MEM_W/8-1:0]     mem_be_o,
   output logic [MEM_W-1:0]       mem_wdata_o,
   input  logic                   mem_rvalid_i,
   input  logic                   mem_err_i,
   input  logic [MEM_W-1:0]       mem_rdata_i,

   output logic [$clog2(DEPTH):0] outstanding_o,
   output logic                   unexp_rsp_o
);

   localparam int LANE_BITS = calc_lane_w(MEM_W);
   localparam int NUM_LANES = MEM_W / 32;
   localparam int CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

   logic             gnt_instr;
   logic             gnt_data;
   logic             gnt_xif;
   logic             any_gnt;
   logic             grant_ok;
   logic             promote;
   logic             pop;
   logic [3:0]       starve_cnt_q;
   logic             unexp_q;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ENTRY_W-1:0] fifo_head_raw;
   trk_entry_t       head_entry;
   trk_entry_t       push_entry;
   logic [LANE_W-1:0] push_lane;
   logic [31:0]      instr_lane_data;

`ifdef MEM_ARB_RR_EN
   logic             rr_last_q;
`endif

   // A slot is available when the FIFO has room, or when a response pops
   // the head in this same cycle. Responses never arrive in the cycle of
   // their own request, so a response seen while full always pops.
   assign grant_ok = !fifo_full || mem_rvalid_i;
   assign promote  = (starve_cnt_q == STARVE_MAX);
   assign any_gnt  = gnt_instr || gnt_data || gnt_xif;

   // Single-winner arbitration. A starved fetch takes top priority for one
   // cycle. Otherwise data and xif compete (fixed or alternating) and instr
   // goes last. Nothing is granted while in reset.
   always_comb begin
      gnt_instr = 1'b0;
      gnt_data  = 1'b0;
      gnt_xif   = 1'b0;
      if (!rst_i && grant_ok) begin
         if (promote && instr_req_i) begin
            gnt_instr = 1'b1;
         end else if (data_req_i && xif_req_i) begin
`ifdef MEM_ARB_RR_EN
            if (rr_last_q) begin
               gnt_data = 1'b1;
            end else begin
               gnt_xif = 1'b1;
            end
`else
            gnt_data = 1'b1;
`endif
         end else if (data_req_i) begin
            gnt_data = 1'b1;
         end else if (xif_req_i) begin
            gnt_xif = 1'b1;
         end else if (instr_req_i) begin
            gnt_instr = 1'b1;
         end
      end
   end

   assign instr_gnt_o = gnt_instr;
   assign data_gnt_o  = gnt_data;
   assign xif_gnt_o   = gnt_xif;

   // Request mux. A fetch is always a full-word read. With no winner the
   // memory sees all zeros.
   always_comb begin
      mem_req_o   = any_gnt;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (gnt_data) begin
         mem_addr_o  = data_addr_i;
         mem_we_o    = data_we_i;
         mem_be_o    = data_be_i;
         mem_wdata_o = data_wdata_i;
      end else if (gnt_xif) begin
         mem_addr_o  = xif_addr_i;
         mem_we_o    = xif_we_i;
         mem_be_o    = xif_be_i;
         mem_wdata_o = xif_wdata_i;
      end else if (gnt_instr) begin
         mem_addr_o  = instr_addr_i;
         mem_be_o    = '1;
      end
   end

   // The lane index exists only when the memory word is wider than 32 bits.
   generate
      if (LANE_BITS > 0) begin : g_lane
         assign push_lane = LANE_W'(mem_addr_o[LANE_BITS+1:2]);
      end else begin : g_no_lane
         assign push_lane = '0;
      end
   endgenerate

   // Build the tracking entry for the current winner.
   always_comb begin
      push_entry.src  = SRC_INSTR;
      push_entry.lane = push_lane;
      if (gnt_data) begin
         push_entry.src = SRC_DATA;
      end else if (gnt_xif) begin
         push_entry.src = SRC_XIF;
      end
   end

   assign pop = !rst_i && mem_rvalid_i && !fifo_empty;

   mem_arb_trk_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_trk_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (any_gnt),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (fifo_head_raw),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign head_entry = fifo_head_raw;

   // Pick the 32-bit lane recorded for the head fetch out of the memory word.
   always_comb begin
      instr_lane_data = mem_rdata_i[31:0];
      for (int i = 0; i < NUM_LANES; i++) begin
         if (head_entry.lane == LANE_W'(i)) begin
            instr_lane_data = mem_rdata_i[32*i +: 32];
         end
      end
   end

   // Only the requester at the head of the FIFO sees the response.
   assign instr_rvalid_o = pop && (head_entry.src == SRC_INSTR);
   assign data_rvalid_o  = pop && (head_entry.src == SRC_DATA);
   assign xif_rvalid_o   = pop && (head_entry.src == SRC_XIF);
   assign instr_err_o    = instr_rvalid_o && mem_err_i;
   assign data_err_o     = data_rvalid_o && mem_err_i;
   assign xif_err_o      = xif_rvalid_o && mem_err_i;
   assign instr_rdata_o  = rst_i ? '0 : instr_lane_data;
   assign data_rdata_o   = rst_i ? '0 : mem_rdata_i;
   assign xif_rdata_o    = rst_i ? '0 : mem_rdata_i;

   assign outstanding_o  = rst_i ? '0 : fifo_count;
   assign unexp_rsp_o    = unexp_q && !rst_i;

   // Count consecutive cycles in which a pending fetch loses arbitration.
   // The count saturates at the promotion level. It clears as soon as the
   // fetch wins or is withdrawn.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (!instr_req_i || gnt_instr) begin
         starve_cnt_q <= '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
         starve_cnt_q <= starve_cnt_q + 4'd1;
      end
   end

   // A response with nothing outstanding is a protocol error. This covers
   // responses to requests discarded by a reset. The flag stays set until
   // the next reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         unexp_q <= 1'b0;
      end else if (mem_rvalid_i && fifo_empty) begin
         unexp_q <= 1'b1;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember which of data/xif was granted last. 1 means xif, so data is
   // favoured next. The reset value 0 favours xif first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_last_q <= 1'b0;
      end else if (gnt_xif) begin
         rr_last_q <= 1'b1;
      end else if (gnt_data) begin
         rr_last_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Configuration: MEM_W=64, DEPTH=8, STARVE_LIM=4.
// Expected response routing is kept in a scoreboard queue: an entry is
// pushed for every grant the bench expects, and popped when the bench
// drives the matching memory response.

module tb_mem_port_arbiter;

   localparam int MEM_W      = 64;
   localparam int DEPTH      = 8;
   localparam int STARVE_LIM = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   logic        instr_req_i = 1'b0;
   logic [31:0] instr_addr_i = '0;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;

   logic        data_req_i = 1'b0;
   logic [31:0] data_addr_i = '0;
   logic        data_we_i = 1'b0;
   logic [7:0]  data_be_i = '0;
   logic [63:0] data_wdata_i = '0;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [63:0] data_rdata_o;

   logic        xif_req_i = 1'b0;
   logic [31:0] xif_addr_i = '0;
   logic        xif_we_i = 1'b0;
   logic [7:0]  xif_be_i = '0;
   logic [63:0] xif_wdata_i = '0;
   logic        xif_gnt_o, xif_rvalid_o, xif_err_o;
   logic [63:0] xif_rdata_o;

   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic        mem_err_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;

   logic [3:0]  outstanding_o;
   logic        unexp_rsp_o;

   typedef struct {
      int   src;
      logic lane;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(
      .MEM_W      (MEM_W),
      .DEPTH      (DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .data_req_i     (data_req_i),
      .data_addr_i    (data_addr_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .xif_req_i      (xif_req_i),
      .xif_addr_i     (xif_addr_i),
      .xif_we_i       (xif_we_i),
      .xif_be_i       (xif_be_i),
      .xif_wdata_i    (xif_wdata_i),
      .xif_gnt_o      (xif_gnt_o),
      .xif_rvalid_o   (xif_rvalid_o),
      .xif_rdata_o    (xif_rdata_o),
      .xif_err_o      (xif_err_o),
      .mem_req_o      (mem_req_o),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_err_i      (mem_err_i),
      .mem_rdata_i    (mem_rdata_i),
      .outstanding_o  (outstanding_o),
      .unexp_rsp_o    (unexp_rsp_o)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   // Drive request lines for one cycle and take the memory response line low.
   task automatic applyStimulus(input logic dr, input logic [31:0] da,
                                input logic xr, input logic [31:0] xa,
                                input logic ir, input logic [31:0] ia);
      data_req_i   = dr;
      data_addr_i  = da;
      xif_req_i    = xr;
      xif_addr_i   = xa;
      instr_req_i  = ir;
      instr_addr_i = ia;
      mem_rvalid_i = 1'b0;
      mem_err_i    = 1'b0;
   endtask

   task automatic checkGrants(input string tag, input logic [2:0] exp_dxi);
      checkOutput({tag, "_gnt"}, {data_gnt_o, xif_gnt_o, instr_gnt_o}, exp_dxi);
      checkOutput({tag, "_memreq"}, mem_req_o, |exp_dxi);
   endtask

   task automatic pushExp(input int src, input logic lane);
      exp_t e;
      e.src  = src;
      e.lane = lane;
      sb.push_back(e);
   endtask

   // Compare the response outputs against the oldest scoreboard entry.
   task automatic checkRsp(input string tag, input logic [63:0] rdata, input logic err);
      exp_t e;
      logic [2:0] rv;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
         return;
      end
      e  = sb.pop_front();
      rv = {e.src == 0, e.src == 1, e.src == 2};
      checkOutput({tag, "_rvalid"}, {instr_rvalid_o, data_rvalid_o, xif_rvalid_o}, rv);
      checkOutput({tag, "_err"}, {instr_err_o, data_err_o, xif_err_o}, err ? rv : 3'b000);
      if (e.src == 0) begin
         checkOutput({tag, "_irdata"}, instr_rdata_o, e.lane ? rdata[63:32] : rdata[31:0]);
      end else if (e.src == 1) begin
         checkOutput({tag, "_drdata"}, data_rdata_o, rdata);
      end else begin
         checkOutput({tag, "_xrdata"}, xif_rdata_o, rdata);
      end
   endtask

   task automatic respondOne(input string tag, input logic [63:0] rdata, input logic err);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      mem_err_i    = err;
      @(negedge clk_i);
      checkRsp(tag, rdata, err);
   endtask

   task automatic drain(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         respondOne(tag, {$urandom, $urandom}, (i % 3) == 1);
      end
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput({tag, "_empty"}, outstanding_o, 0);
   endtask

   task automatic doReset(input string tag);
      nextCycle();
      rst_i = 1'b1;
      applyStimulus(1, 32'h40, 1, 32'h80, 1, 32'hC0);
      @(negedge clk_i);
      checkGrants({tag, "_inrst"}, 3'b000);
      nextCycle();
      rst_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      sb.delete();
      @(negedge clk_i);
      checkOutput({tag, "_outst"}, outstanding_o, 0);
      checkOutput({tag, "_unexp"}, unexp_rsp_o, 0);
   endtask

   initial begin
      // Reset with every requester asserted: nothing may be granted.
      rst_i = 1'b1;
      applyStimulus(1, 32'h10, 1, 32'h20, 1, 32'h30);
      @(negedge clk_i);
      checkGrants("reset", 3'b000);
      checkOutput("reset_outst", outstanding_o, 0);
      checkOutput("reset_unexp", unexp_rsp_o, 0);
      nextCycle();
      rst_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("post_reset_outst", outstanding_o, 0);

      // Simultaneous requests: data wins, then xif, then instr.
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h200, 1, 32'h304);
      data_we_i    = 1'b1;
      data_be_i    = 8'h0F;
      data_wdata_i = 64'hDEADBEEF_CAFEF00D;
      xif_we_i     = 1'b1;
      xif_be_i     = 8'hF0;
      xif_wdata_i  = 64'h01234567_89ABCDEF;
      @(negedge clk_i);
      checkGrants("simul", 3'b100);
      checkOutput("simul_addr", mem_addr_o, 32'h100);
      checkOutput("simul_webe", {mem_we_o, mem_be_o}, 9'h10F);
      checkOutput("simul_wdata", mem_wdata_o, 64'hDEADBEEF_CAFEF00D);
      pushExp(1, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 1, 32'h200, 1, 32'h304);
      @(negedge clk_i);
      checkGrants("xif", 3'b010);
      checkOutput("xif_addr", mem_addr_o, 32'h200);
      checkOutput("xif_wdata", mem_wdata_o, 64'h01234567_89ABCDEF);
      pushExp(2, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 32'h304);
      @(negedge clk_i);
      checkGrants("instr", 3'b001);
      checkOutput("instr_addr", mem_addr_o, 32'h304);
      checkOutput("instr_attr", {mem_we_o, mem_be_o, mem_wdata_o}, {1'b0, 8'hFF, 64'h0});
      pushExp(0, 1'b1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("simul_outst", outstanding_o, 3);
      drain("simul_rsp", 3);

      // Starvation: held data traffic, instr promoted on the 5th denied cycle.
      for (int k = 1; k <= 6; k++) begin
         nextCycle();
         applyStimulus(1, 32'h400 + 32'(k * 4), 0, 0, 1, (k <= 5) ? 32'h500 : 32'h508);
         @(negedge clk_i);
         if (k == 5) begin
            checkGrants($sformatf("starve%0d", k), 3'b001);
            pushExp(0, 1'b0);
         end else begin
            checkGrants($sformatf("starve%0d", k), 3'b100);
            pushExp(1, 1'b0);
         end
      end
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("starve_outst", outstanding_o, 6);
      drain("starve_rsp", 6);

      // Full FIFO: 8 grants, 9th refused, then accepted alongside a pop.
      for (int k = 0; k < 8; k++) begin
         nextCycle();
         applyStimulus(1, 32'h1000 + 32'(k * 8), 0, 0, 0, 0);
         @(negedge clk_i);
         checkGrants($sformatf("fill%0d", k), 3'b100);
         pushExp(1, 1'b0);
      end
      nextCycle();
      applyStimulus(1, 32'h2000, 0, 0, 0, 0);
      @(negedge clk_i);
      checkGrants("full_block", 3'b000);
      checkOutput("full_outst", outstanding_o, 8);
      nextCycle();
      applyStimulus(1, 32'h2000, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h5555AAAA_0F0F1234;
      @(negedge clk_i);
      checkGrants("full_pop", 3'b100);
      checkRsp("full_pop_rsp", 64'h5555AAAA_0F0F1234, 1'b0);
      pushExp(1, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("full_pop_outst", outstanding_o, 8);
      drain("full_rsp", 8);

      // Lane select on a 64-bit memory word.
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 32'h84);
      @(negedge clk_i);
      checkGrants("lane_hi", 3'b001);
      pushExp(0, 1'b1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 32'h80);
      @(negedge clk_i);
      checkGrants("lane_lo", 3'b001);
      pushExp(0, 1'b0);
      respondOne("lane_hi_rsp", 64'h11112222_33334444, 1'b0);
      checkOutput("lane_hi_const", instr_rdata_o, 32'h11112222);
      respondOne("lane_lo_rsp", 64'hAAAABBBB_CCCCDDDD, 1'b1);
      checkOutput("lane_lo_const", instr_rdata_o, 32'hCCCCDDDD);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Data/xif contention from a fresh reset.
      doReset("rr_rst");
      for (int k = 0; k < 4; k++) begin
         nextCycle();
         applyStimulus(1, 32'h3000 + 32'(k * 4), 1, 32'h4000 + 32'(k * 4), 0, 0);
         @(negedge clk_i);
`ifdef MEM_ARB_RR_EN
         checkGrants($sformatf("rr%0d", k), (k % 2 == 0) ? 3'b010 : 3'b100);
         pushExp((k % 2 == 0) ? 2 : 1, 1'b0);
`else
         checkGrants($sformatf("rr%0d", k), 3'b100);
         pushExp(1, 1'b0);
`endif
      end
      drain("rr_rsp", 4);

      // Unexpected response with nothing outstanding.
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'hFFFF0000_FFFF0000;
      @(negedge clk_i);
      checkOutput("unexp_rv", {instr_rvalid_o, data_rvalid_o, xif_rvalid_o}, 3'b000);
      checkOutput("unexp_pre", unexp_rsp_o, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("unexp_set", unexp_rsp_o, 1);
      checkOutput("unexp_outst", outstanding_o, 0);
      doReset("unexp_rst");

      // Reset mid-operation: the response to a discarded request is unexpected.
      nextCycle();
      applyStimulus(1, 32'h5000, 0, 0, 0, 0);
      @(negedge clk_i);
      checkGrants("midrst_req", 3'b100);
      doReset("midrst");
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      mem_rvalid_i = 1'b1;
      @(negedge clk_i);
      checkOutput("midrst_rv", {instr_rvalid_o, data_rvalid_o, xif_rvalid_o}, 3'b000);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      checkOutput("midrst_unexp", unexp_rsp_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single SoC memory port between the cv32e40x instruction fetch interface, the cv32e40x data interface and the XAVA coprocessor memory requests. Sits between the core, the XAVA adaptor and the external memory. Tracks every outstanding transaction in an in-order FIFO and returns each response only to the requester that issued it. Keeps instruction fetch from being starved.

## Interface
- `MEM_W`, 32: memory data width in bits. Must be a power of two and at least 32.
- `DEPTH`, 8: maximum number of outstanding transactions. Must be a power of two and at least 2.
- `STARVE_LIM`, 4: number of consecutive denied cycles after which instruction fetch is promoted. Range 1 to 15.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `instr_req_i` in 1, `instr_addr_i` in 32: fetch request.
- `instr_gnt_o` out 1: fetch request accepted.
- `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: fetch response.
- `data_req_i` in 1, `data_addr_i` in 32, `data_we_i` in 1, `data_be_i` in MEM_W/8, `data_wdata_i` in MEM_W: core load/store request.
- `data_gnt_o` out 1: core load/store request accepted.
- `data_rvalid_o` out 1, `data_rdata_o` out MEM_W, `data_err_o` out 1: core load/store response.
- `xif_req_i` in 1, `xif_addr_i` in 32, `xif_we_i` in 1, `xif_be_i` in MEM_W/8, `xif_wdata_i` in MEM_W: coprocessor request.
- `xif_gnt_o` out 1: coprocessor request accepted.
- `xif_rvalid_o` out 1, `xif_rdata_o` out MEM_W, `xif_err_o` out 1: coprocessor response.
- `mem_req_o` out 1, `mem_addr_o` out 32, `mem_we_o` out 1, `mem_be_o` out MEM_W/8, `mem_wdata_o` out MEM_W: memory request. The memory accepts every request in the cycle it is issued.
- `mem_rvalid_i` in 1, `mem_err_i` in 1, `mem_rdata_i` in MEM_W: memory response. Responses return in order, at least 1 cycle after the request.
- `outstanding_o` out $clog2(DEPTH)+1: current FIFO occupancy.
- `unexp_rsp_o` out 1: sticky flag, set by a response that arrives while the FIFO is empty.

## Operation
- **Grant eligibility:** a grant is allowed when `count < DEPTH`, or when `mem_rvalid_i` is high in the same cycle (a pop frees a slot).
- **Grant rule:** at most one grant per cycle.
  - Default priority order is data, then xif, then instr.
  - If `starve_cnt == STARVE_LIM`, instr has top priority for that cycle.
- **Request mux:**
  - `mem_req_o` equals the OR of all grants.
  - Address, write-enable, byte-enable and write data are taken from the granted requester.
  - When the winner is instr: `mem_we_o` is 0, `mem_be_o` is all ones, `mem_wdata_o` is 0.
  - With no grant, all `mem_*` outputs are 0.
- **Tracking FIFO:** on each grant, push {src[1:0], addr lane bits} into the FIFO.
  - src encoding: 0 = instr, 1 = data, 2 = xif.
  - The lane bits are `addr[$clog2(MEM_W/8)-1:2]`; the field is absent when MEM_W = 32.
  - Push and pop in the same cycle leave `count` unchanged, and the pointers wrap modulo DEPTH.
- **Response routing:** when `mem_rvalid_i` is high and the FIFO is not empty, raise the rvalid/err outputs of the head source only, then pop.
  - `instr_rdata_o` is the 32-bit lane of `mem_rdata_i` selected by the stored lane bits.
  - `data_rdata_o` and `xif_rdata_o` carry `mem_rdata_i` unmodified.
- **Unexpected response:** `mem_rvalid_i` with an empty FIFO causes no rvalid output, no pop, and sets `unexp_rsp_o`, which stays set until reset.
- **Starvation counter `starve_cnt`:**
  - Increments, saturating at STARVE_LIM, while `instr_req_i` is high and instr is not granted.
  - Clears to 0 on an instr grant or when `instr_req_i` is low.

## Timing
- `*_gnt_o` and `mem_*` request outputs are combinational from the `*_req_i` inputs, `count`, `starve_cnt` and `mem_rvalid_i` (the full-with-pop case). Same cycle.
- Response outputs are combinational from `mem_rvalid_i` and the FIFO head. Zero added latency.
- FIFO, `count`, `starve_cnt`, `rr_last` and `unexp_rsp_o` update on the rising clock edge.
- **Reset values:** `count`=0, pointers=0, `starve_cnt`=0, `rr_last`=0 (xif favoured first), `unexp_rsp_o`=0. All outputs are 0 while `rst_i` is high, including grants.
- **Reset mid-operation:** all tracked transactions are discarded. Any later response for a pre-reset request sets `unexp_rsp_o`; it is not routed.
- **Requester handshake:** a requester holds its request and its attributes stable until granted. The arbiter never grants a request that is not asserted.

## Configuration
- `MEM_ARB_RR_EN` defined: data and xif alternate priority.
  - The `rr_last` flop records the last of the two that was granted.
  - The other one wins the next contention between them.
  - instr stays lowest priority, except when promoted by starvation.
- Not defined: fixed priority data, then xif, then instr. There is no `rr_last` flop.

## Structure
- Package `mem_arb_pkg`:
  - `src_e` enum (SRC_INSTR, SRC_DATA, SRC_XIF).
  - `trk_entry_t` struct (src, lane).
  - `LANE_W` constant, computed from MEM_W.
- Sub-module `mem_arb_trk_fifo`: parameterised synchronous FIFO with push, pop, head, count, full and empty. Instantiated once.

## Test plan
- **Simultaneous requests:** data, xif and instr requests asserted in the same cycle -> `data_gnt_o`=1 only, `mem_addr_o`=`data_addr_i`, FIFO head src=1.
- **Starvation guard:** data request held continuously with instr requesting, STARVE_LIM=4 -> instr granted on the 5th cycle, `starve_cnt` back to 0 on the next cycle.
- **Full FIFO:** DEPTH=8, 8 data grants issued with no response -> a 9th request gets no grant. With `mem_rvalid_i` high in that cycle -> granted, `outstanding_o` stays 8.
- **Lane select:** MEM_W=64, instr fetch at 0x84 -> response `mem_rdata_i`=0x11112222_33334444 gives `instr_rdata_o`=0x11112222. Data and xif see no rvalid.
- **Round-robin (`MEM_ARB_RR_EN`):** data and xif both requesting for 4 cycles -> grant sequence xif, data, xif, data. Without the macro -> data on all 4 cycles.
- **Unexpected response:** `mem_rvalid_i` pulse with an empty FIFO -> no rvalid output and `unexp_rsp_o`=1. Then `rst_i` high for 1 cycle -> `unexp_rsp_o`=0 and `outstanding_o`=0.
